// File: rtl/riscv_pkg.sv
// Shared core definitions: machine/instruction widths, the canonical NOP
// encoding and the instruction fetch FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // REQ: imem_req high; WAIT: granted, awaiting rvalid; STALL: no room to fetch
  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_STALL
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} entries.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          drop all entries (wins over push/pop)
//   push/push_data write one entry
//   pop            consume the head entry
//   head           current head entry (registered storage)
//   count          number of valid entries, 0..DEPTH
//   full/empty     occupancy flags
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, issues word requests over a
// req/gnt/rvalid bus (one outstanding at most), buffers returned words in a
// prefetch FIFO and hands them to decode over valid/ready. A redirect flushes
// the FIFO and restarts fetch at the new address.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req, imem_addr                request and word-aligned byte address
//   imem_gnt, imem_rvalid, imem_rdata  grant, in-order response data
//   redirect_valid, redirect_pc        flush and restart fetch
//   id_valid, id_ready, id_instr, id_pc  decode handshake and payload
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state, state_nx;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nx;
  logic [XLEN-1:0] out_pc, out_pc_nx;
  logic            discard, discard_nx;

  logic                 push, pop, gnt_ok;
  logic [CW-1:0]        fifo_count, level_after;
  logic                 fifo_full, fifo_empty;
  logic [XLEN+ILEN-1:0] fifo_head;

  // A grant only counts while our request is actually on the bus.
  assign gnt_ok = imem_req & imem_gnt;
  assign pop    = ~fifo_empty & id_ready;

  // Occupancy once the returning word is pushed and any pop this cycle retires.
  assign level_after = fifo_count + CW'(1) - CW'(pop);

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    out_pc_nx   = out_pc;
    discard_nx  = discard;
    push        = 1'b0;
    if (redirect_valid) begin
      fetch_pc_nx = {redirect_pc[XLEN-1:2], 2'b00};
      case (state)
        // A response arriving now retires the stale request; otherwise it
        // is still in flight and must be dropped when it lands.
        ST_WAIT: begin
          if (imem_rvalid) begin
            state_nx   = ST_REQ;
            discard_nx = 1'b0;
          end else begin
            state_nx   = ST_WAIT;
            discard_nx = 1'b1;
          end
        end
        ST_REQ: begin
          if (gnt_ok) begin
            state_nx   = ST_WAIT;
            discard_nx = 1'b1;
          end else begin
            state_nx = ST_REQ;
          end
        end
        default: state_nx = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (gnt_ok) begin
            state_nx    = ST_WAIT;
            out_pc_nx   = fetch_pc;
            fetch_pc_nx = fetch_pc + 32'd4;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard_nx = 1'b0;
              state_nx   = (fifo_full && !pop) ? ST_STALL : ST_REQ;
            end else begin
              push     = 1'b1;
              state_nx = (level_after < CW'(FIFO_DEPTH)) ? ST_REQ : ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (!fifo_full || pop) state_nx = ST_REQ;
        end
        default: state_nx = ST_REQ;
      endcase
    end
  end

  // ---- fetch control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      imem_req <= 1'b0;
      fetch_pc <= RESET_PC;
      out_pc   <= '0;
      discard  <= 1'b0;
    end else begin
      state    <= state_nx;
      imem_req <= (state_nx == ST_REQ);
      fetch_pc <= fetch_pc_nx;
      out_pc   <= out_pc_nx;
      discard  <= discard_nx;
    end
  end

  assign imem_addr = fetch_pc;

  // ---- prefetch buffer ----
  fetch_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({out_pc, imem_rdata}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign id_valid = ~fifo_empty;
  assign id_pc    = fifo_head[XLEN+ILEN-1:ILEN];
  assign id_instr = fifo_head[ILEN-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios push expected
// grant addresses and delivered {pc, instr} words; a monitor pops and compares.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_id[$];

  int          gnt_count = 0;
  int          gnt_limit = 0;
  int          lat = 1;
  logic        pending = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] pend_addr = '0;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_addr.push_back(pc);
    exp_id.push_back({pc, mem_word(pc)});
  endtask

  task automatic wait_gnts(input int target);
    int n = 0;
    while (gnt_count < target && n < 200) begin
      step();
      n++;
    end
    if (gnt_count < target) begin
      vectors++;
      miscompares++;
      $display("FAIL gnt_timeout: got %0d grants, want %0d", gnt_count, target);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_id.size() != 0 || exp_addr.size() != 0) && n < 300) begin
      step();
      n++;
    end
    repeat (6) step();
    chk({tag, "_id_left"}, 32'(exp_id.size()), 32'd0);
    chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_id_instr"}, id_instr, 32'h0);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
  endtask

  // Memory model: grants while under gnt_limit, answers lat cycles later.
  initial forever begin
    @(posedge clk);
    #1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (wait_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pending     = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (imem_req && !pending && gnt_count < gnt_limit) begin
        imem_gnt  = 1'b1;
        pending   = 1'b1;
        wait_cnt  = lat;
        pend_addr = imem_addr;
        gnt_count++;
      end
    end
  end

  // Monitor: granted addresses and consumed decode words against the queues.
  initial forever begin
    logic [31:0] ea;
    logic [63:0] ew;
    @(negedge clk);
    if (rst_n) begin
      if (imem_req && imem_gnt) begin
        if (exp_addr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_grant: addr %h, none expected", imem_addr);
        end else begin
          ea = exp_addr.pop_front();
          chk("imem_addr", imem_addr, ea);
        end
      end
      if (id_valid && id_ready) begin
        if (exp_id.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: pc %h instr %h, none expected", id_pc, id_instr);
        end else begin
          ew = exp_id.pop_front();
          chk("id_pc", id_pc, ew[63:32]);
          chk("id_instr", id_instr, ew[31:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;

    // Reset state and basic in-order fetch with single-cycle memory.
    rst_n = 1'b0;
    id_ready = 1'b1;
    lat = 1;
    step();
    step();
    check_reset_outputs("reset");
    gnt_limit = gnt_count + 3;
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h8);
    rst_n = 1'b1;
    drain("basic");

    // Decode backpressure: FIFO fills to depth, fetch stalls, head is held.
    rst_n = 1'b0;
    step();
    step();
    id_ready = 1'b0;
    g0 = gnt_count;
    gnt_limit = g0 + 5;
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h8);
    expect_word(32'hC);
    expect_word(32'h10);
    rst_n = 1'b1;
    repeat (8) step();
    chk("stall_grants", 32'(gnt_count - g0), 32'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(id_valid), 32'd1);
      chk("stall_pc", id_pc, 32'h0);
      chk("stall_instr", id_instr, mem_word(32'h0));
    end
    chk("stall_grants_after", 32'(gnt_count - g0), 32'd2);
    id_ready = 1'b1;
    drain("stall");

    // Redirect while a request is outstanding: stale response is dropped.
    rst_n = 1'b0;
    step();
    step();
    lat = 3;
    g0 = gnt_count;
    gnt_limit = g0 + 4;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h100);
    exp_addr.push_back(32'h104);
    exp_addr.push_back(32'h108);
    exp_id.push_back({32'h100, mem_word(32'h100)});
    exp_id.push_back({32'h104, mem_word(32'h104)});
    exp_id.push_back({32'h108, mem_word(32'h108)});
    rst_n = 1'b1;
    wait_gnts(g0 + 1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("redir_id_valid", 32'(id_valid), 32'd0);
    drain("redir_out");

    // Redirect of an ungranted request: retargeted, request stays high.
    rst_n = 1'b0;
    step();
    step();
    lat = 1;
    g0 = gnt_count;
    gnt_limit = g0;
    rst_n = 1'b1;
    repeat (3) step();
    chk("retgt_req_before", 32'(imem_req), 32'd1);
    chk("retgt_addr_before", imem_addr, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    chk("retgt_addr", imem_addr, 32'h200);
    chk("retgt_req", 32'(imem_req), 32'd1);
    step();
    step();
    chk("retgt_addr_hold", imem_addr, 32'h200);
    expect_word(32'h200);
    gnt_limit = g0 + 1;
    drain("retarget");

    // Address wrap at the top of the address space.
    rst_n = 1'b0;
    step();
    step();
    g0 = gnt_count;
    gnt_limit = g0;
    rst_n = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    expect_word(32'hFFFF_FFF8);
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0000_0000);
    gnt_limit = g0 + 3;
    drain("wrap");

    // Asynchronous reset in the middle of a WAIT, then restart at RESET_PC.
    rst_n = 1'b0;
    step();
    step();
    id_ready = 1'b0;
    lat = 3;
    g0 = gnt_count;
    gnt_limit = g0 + 2;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    rst_n = 1'b1;
    wait_gnts(g0 + 2);
    step();
    chk("midwait_valid", 32'(id_valid), 32'd1);
    chk("midwait_pc", id_pc, 32'h0);
    chk("midwait_addr", imem_addr, 32'h8);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step();
    step();
    lat = 1;
    id_ready = 1'b1;
    g0 = gnt_count;
    gnt_limit = g0 + 3;
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h8);
    rst_n = 1'b1;
    drain("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
